// File: rtl/gpio_seg_display_pkg.sv
// Shared definitions for the GPIO seven-segment display path.
//   disp_state_t : conversion FSM states
//   SEG_BLANK    : all segments off (active-low)
//   SEG_CODES    : active-low segment patterns for hex digits 0..F
//   dd_step      : one double-dabble step (add-3 correction, then shift left)
package display_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned BCD_DIGITS = 10;
    localparam int unsigned CONV_STEPS = 32;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_COMMIT
    } disp_state_t;

    // BCD accumulator sits above the binary working register so that one
    // left shift of the pair moves the binary MSB into BCD digit 0.
    typedef struct packed {
        logic [4*BCD_DIGITS-1:0] bcd;
        logic [31:0]             bin;
    } dd_state_t;

    function automatic dd_state_t dd_step(input dd_state_t s);
        logic [4*BCD_DIGITS-1:0] adj;
        dd_state_t               r;
        adj = s.bcd;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        r = {adj, s.bin} << 1;
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit to active-low seven-segment decoder.
//   nibble : digit value 0..F
//   seg    : segment pattern, bit0 = a ... bit6 = g, active-low
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_CODES[nibble];
    end

endmodule

// File: rtl/gpio_seg_display.sv
// Converts the CPU gpio_out value into eight active-low seven-segment
// digit patterns, in hex or unsigned decimal (sequential double-dabble).
//   clk, rst  : system clock, asynchronous active-high reset
//   value_in  : 32-bit value to display
//   dec_mode  : 0 = hexadecimal, 1 = unsigned decimal
//   hex_segs  : digit k on bits [7k+6:7k], active-low, digit 0 least significant
//   busy      : decimal conversion in progress
//   ovf       : decimal value needs more than 8 digits
module gpio_seg_display
    import display_pkg::*;
#(
    parameter bit BLANK_ZEROS = 1'b1
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             value_in,
    input  logic                    dec_mode,
    output logic [7*NUM_DIGITS-1:0] hex_segs,
    output logic                    busy,
    output logic                    ovf
);

    disp_state_t state, state_next;

    logic [31:0] shown_val;
    logic        shown_mode;
    logic        shown_vld;
    dd_state_t   dd;
    dd_state_t   dd_next;
    logic [4:0]  step;
    logic        request;

    logic [3:0]              nib     [NUM_DIGITS];
    logic [6:0]              seg_raw [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank;
    logic [7*NUM_DIGITS-1:0] segs_next;

    assign request = !shown_vld || (value_in != shown_val) || (dec_mode != shown_mode);
    assign dd_next = dd_step(dd);

    // In hex mode the working register is never shifted, so it still holds
    // the captured value; in decimal mode the BCD accumulator holds the result.
    always_comb begin
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            nib[k] = shown_mode ? dd.bcd[4*k +: 4] : dd.bin[4*k +: 4];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .nibble (nib[g]),
            .seg    (seg_raw[g])
        );
    end

    // Scan from the top digit down; everything above the first nonzero
    // digit is blanked. Digit 0 is never blanked.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
            if (nib[NUM_DIGITS-1-i] != 4'd0)
                seen = 1'b1;
            blank[NUM_DIGITS-1-i] = BLANK_ZEROS && !seen;
        end
        segs_next = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            segs_next[7*k +: 7] = blank[k] ? SEG_BLANK : seg_raw[k];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (request) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = dec_mode ? ST_SHIFT : ST_COMMIT;
            ST_SHIFT:   if (step == 5'(CONV_STEPS - 1)) state_next = ST_COMMIT;
            ST_COMMIT:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shown_val  <= '0;
            shown_mode <= 1'b0;
            shown_vld  <= 1'b0;
            dd         <= '0;
            step       <= '0;
            hex_segs   <= '1;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request)
                        busy <= dec_mode;
                end
                ST_CAPTURE: begin
                    dd.bcd     <= '0;
                    dd.bin     <= value_in;
                    shown_val  <= value_in;
                    shown_mode <= dec_mode;
                    step       <= '0;
                    busy       <= dec_mode;
                end
                ST_SHIFT: begin
                    dd   <= dd_next;
                    step <= step + 5'd1;
                end
                ST_COMMIT: begin
                    hex_segs  <= segs_next;
                    ovf       <= shown_mode && (dd.bcd[4*BCD_DIGITS-1:4*NUM_DIGITS] != '0);
                    shown_vld <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_seg_display.sv
module tb_gpio_seg_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] value_in = 32'h1234ABCD;
    logic        dec_mode = 1'b0;
    logic [55:0] hex_segs, hex_segs0;
    logic        busy, busy0, ovf, ovf0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gpio_seg_display #(.BLANK_ZEROS(1'b1)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .dec_mode(dec_mode),
        .hex_segs(hex_segs), .busy(busy), .ovf(ovf)
    );

    gpio_seg_display #(.BLANK_ZEROS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .value_in(value_in), .dec_mode(dec_mode),
        .hex_segs(hex_segs0), .busy(busy0), .ovf(ovf0)
    );

    localparam logic [6:0] TB_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Display image straight from arithmetic: radix-10 or radix-16 digits.
    function automatic logic [55:0] exp_segs(input logic [31:0] v, input logic m, input bit blank_en);
        logic [3:0] d [8];
        int top;
        logic [55:0] r;
        longint unsigned x;
        x = v;
        top = 0;
        for (int k = 0; k < 8; k++) begin
            if (m) begin d[k] = 4'(x % 10); x = x / 10; end
            else   begin d[k] = 4'(x % 16); x = x / 16; end
            if (d[k] != 4'd0) top = k;
        end
        for (int k = 0; k < 8; k++)
            r[7*k +: 7] = (blank_en && k > top) ? 7'h7F : TB_SEG[d[k]];
        return r;
    endfunction

    task automatic chk56(input string name, input logic [55:0] act, input logic [55:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %014h expected %014h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Latency model: request seen in idle -> capture one edge later ->
    // results appear 1 (hex) or 33 (decimal) edges after capture.
    logic [55:0] m_segs  = '1;
    logic [55:0] m_segs0 = '1;
    logic        m_busy = 1'b0, m_ovf = 1'b0, m_vld = 1'b0, m_mode = 1'b0, p_mode = 1'b0;
    logic [31:0] m_val = '0, p_val = '0;
    int          ph = 0, rem = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 0; rem <= 0;
            m_busy <= 1'b0; m_ovf <= 1'b0; m_vld <= 1'b0;
            m_segs <= '1; m_segs0 <= '1;
        end else begin
            case (ph)
                0: if (!m_vld || value_in != m_val || dec_mode != m_mode) begin
                    ph <= 1; m_busy <= dec_mode;
                end
                1: begin
                    p_val <= value_in; p_mode <= dec_mode; m_busy <= dec_mode;
                    rem <= dec_mode ? 33 : 1; ph <= 2;
                end
                default: begin
                    rem <= rem - 1;
                    if (rem == 1) begin
                        m_segs  <= exp_segs(p_val, p_mode, 1'b1);
                        m_segs0 <= exp_segs(p_val, p_mode, 1'b0);
                        m_ovf   <= p_mode && (p_val > 32'd99999999);
                        m_vld <= 1'b1; m_val <= p_val; m_mode <= p_mode;
                        m_busy <= 1'b0; ph <= 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk56("model_segs", hex_segs, m_segs);
        chk1("model_busy", busy, m_busy);
        chk1("model_ovf", ovf, m_ovf);
        chk56("model_segs_noblank", hex_segs0, m_segs0);
        chk1("model_busy_noblank", busy0, m_busy);
        chk1("model_ovf_noblank", ovf0, m_ovf);
    end

    task automatic wait_not_busy(input int max_cycles);
        bit done;
        done = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL wait_not_busy: busy still 1 after %0d cycles", max_cycles);
        end
    endtask

    initial begin
        int cnt;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk56("reset_segs", hex_segs, {8{7'h7F}});
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_ovf", ovf, 1'b0);

        // hex: 3 edges after release
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk56("hex_1234ABCD", hex_segs,
              {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});
        chk1("hex_ovf", ovf, 1'b0);

        // decimal 12345678, busy width
        @(negedge clk);
        value_in = 32'd12345678; dec_mode = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else if (cnt > 0) break;
        end
        vectors++;
        if (cnt != 34) begin
            miscompares++;
            $display("FAIL busy_width: got %0d cycles expected 34", cnt);
        end
        chk56("dec_12345678", hex_segs,
              {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
        chk1("dec_ovf0", ovf, 1'b0);

        // overflow
        value_in = 32'd100000000;
        repeat (40) @(negedge clk);
        chk56("ovf_segs", hex_segs, {{7{7'h7F}}, 7'h40});
        chk1("ovf_flag", ovf, 1'b1);
        chk56("ovf_segs_noblank", hex_segs0, {8{7'h40}});
        chk1("ovf_flag_noblank", ovf0, 1'b1);

        // change mid-conversion
        value_in = 32'd5;
        repeat (12) @(posedge clk);
        @(negedge clk);
        value_in = 32'd987;
        wait_not_busy(60);
        chk56("mid_first_5", hex_segs, {{7{7'h7F}}, 7'h12});
        chk1("mid_idle_gap", busy, 1'b0);
        @(negedge clk);
        chk1("mid_restart", busy, 1'b1);
        wait_not_busy(60);
        chk56("mid_final_987", hex_segs, {{5{7'h7F}}, 7'h10, 7'h00, 7'h78});

        // async reset mid-conversion
        value_in = 32'd54321;
        repeat (18) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk56("arst_segs", hex_segs, {8{7'h7F}});
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_ovf", ovf, 1'b0);
        @(negedge clk) rst = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        chk1("arst_busy_34", busy, 1'b1);
        chk56("arst_segs_34", hex_segs, {8{7'h7F}});
        @(posedge clk);
        #1;
        chk1("arst_busy_35", busy, 1'b0);
        chk56("arst_54321", hex_segs,
              {{3{7'h7F}}, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});

        // mode toggle with 255
        @(negedge clk);
        value_in = 32'd255; dec_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk56("toggle_hex_FF", hex_segs, {{6{7'h7F}}, 7'h0E, 7'h0E});
        @(negedge clk);
        dec_mode = 1'b1;
        repeat (35) @(posedge clk);
        #1;
        chk56("toggle_dec_255", hex_segs, {{5{7'h7F}}, 7'h24, 7'h12, 7'h12});
        chk1("toggle_ovf", ovf, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpio_seg_display.md
# gpio_seg_display

Output-side consumer of the CPU's `gpio_out` register. It converts the 32-bit value into eight active-low seven-segment digit patterns for the board HEX displays. Hex mode decodes nibbles directly. Decimal mode runs a sequential 32-step shift-and-add-3 (double-dabble) binary-to-BCD conversion. The block sits between `cpu.gpio_out` and the top-level HEX pins and is the only display path for program results.

## Interface
- `BLANK_ZEROS`, default 1: blank leading zero digits. Digit 0 is never blanked.
- `clk`  input  1  system clock, same clock as `cpu`.
- `rst`  input  1  reset. Asynchronous, active-high.
- `value_in`  input  32  value to display, driven from `cpu.gpio_out`.
- `dec_mode`  input  1  0 = hexadecimal, 1 = unsigned decimal.
- `hex_segs`  output  56  digit k on bits [7k+6:7k]; digit 0 is least significant. Within a digit, bit0 = a … bit6 = g; active-low.
- `busy`  output  1  decimal conversion in progress.
- `ovf`  output  1  decimal value exceeds 99,999,999; only the low 8 BCD digits are shown.

## Operation
- **Change detection.**
  - Registers: `shown_val[31:0]`, `shown_mode`, `shown_vld`.
  - A request exists when `!shown_vld`, or `value_in != shown_val`, or `dec_mode != shown_mode`.
- **FSM `IDLE` → `CAPTURE` → `SHIFT` → `COMMIT` → `IDLE`.**
  - `IDLE`: on request, go to `CAPTURE`.
  - `CAPTURE`: latch `value_in` into the working shift register and `shown_val`, latch `dec_mode` into `shown_mode`, and clear the 40-bit BCD accumulator (10 digits). Hex mode goes straight to `COMMIT`; decimal mode goes to `SHIFT` with step counter = 0.
  - `SHIFT`: one step per cycle, 32 steps. Each step first adds 3 to every BCD digit ≥ 5, then shifts {BCD, working} left by 1. Go to `COMMIT` after step 31 (counter wraps 31 → 0).
  - `COMMIT`: load the `hex_segs` register, set `shown_vld`, update `ovf`, return to `IDLE`.
- **Output content.**
  - Hex mode: digit k = seg(nibble k of the latched value); `ovf` = 0.
  - Decimal mode: digit k = seg(BCD digit k) for k = 0..7; `ovf` = (BCD digit 8 ≠ 0) or (BCD digit 9 ≠ 0).
  - Blanking (`BLANK_ZEROS` = 1): digits above the most significant nonzero digit show 7'h7F. Applies in both modes, but is based on displayed digits only, so an overflowed value may blank.
- **Segment codes, digits 0–F:** 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
- **Input changes while not in `IDLE`** are not sampled. On return to `IDLE`, comparison against `shown_val`/`shown_mode` restarts the conversion if the inputs differ. The last value written always wins; intermediate values may be skipped.
- **Reset**, including mid-conversion:
  - `hex_segs` = all 7'h7F (blank), `busy` = 0, `ovf` = 0, `shown_vld` = 0, FSM = `IDLE`, counters = 0.
  - The first conversion starts on the first clock after reset release.

## Timing
- All outputs are registered; `hex_segs` and `ovf` change only on the `COMMIT` edge.
- Hex mode: input change at edge N is sampled, giving `CAPTURE` at N+1, `COMMIT` at N+2; outputs are valid after edge N+3 (3-cycle latency).
- Decimal mode: `CAPTURE` at N+1, `SHIFT` edges N+2..N+33, `COMMIT` N+34; outputs valid after edge N+35.
- `busy` = 1 in states `CAPTURE`, `SHIFT` and `COMMIT` when decimal mode is latched; 0 otherwise.
- Back-to-back requests: `IDLE` lasts exactly one cycle between conversions.
- Maximum decimal value 4,294,967,295 fits 10 BCD digits, so no accumulator overflow is possible.

## Structure
- Package `display_pkg` holds:
  - FSM enum `disp_state_t`;
  - `SEG_BLANK` = 7'h7F;
  - the 16-entry segment constant array;
  - `NUM_DIGITS` = 8, `BCD_DIGITS` = 10, `CONV_STEPS` = 32.
- One sub-module, `seg7_decode`: combinational 4-bit → 7-bit active-low decoder, instantiated 8×.
- The add-3/shift step is a function in the package, not a module.

## Test plan
- **Reset, then hex mode:** `value_in` = 32'h1234ABCD, `dec_mode` = 0. Three cycles after reset release, `hex_segs` digits 7..0 = 79, 24, 30, 19, 08, 03, 46, 21; `busy` stayed 0; `ovf` = 0.
- **Decimal mode:** `value_in` = 12345678, `dec_mode` = 1.
  - `busy` is high for 34 cycles.
  - Then digits 7..0 = 79, 24, 30, 19, 12, 02, 78, 00; `ovf` = 0.
- **Overflow:** `value_in` = 100000000, decimal mode. Digits 7..1 = 7F (blanked), digit 0 = 40, `ovf` = 1. With `BLANK_ZEROS` = 0, all digits = 40.
- **Change mid-conversion:**
  - Input sequence: 5, then 987 at conversion step 10.
  - Display shows 5 (digit 0 = 12, others 7F).
  - A second conversion follows one `IDLE` cycle later; the final display is 987 (10, 00, 78, upper 7F).
- **Async reset mid-conversion:** assert `rst` at step 16 without a clock edge. `hex_segs` becomes all 7F, and `busy` and `ovf` become 0, immediately. After release, reconversion of the held input completes on schedule.
- **Mode toggle** with value 255 held: hex shows FF (0E, 0E); after switching `dec_mode` to 1, 35 cycles later the display shows 255 (24, 12, 12).
